// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative integer divider.
// Latency constants: DIV_LATENCY normal path, DIV_SPECIAL_LATENCY for div-by-zero / overflow.
// Contents: XLEN, data_bus_t, div_ops_e, fu_state_e, div_fsm_e, opcode helper functions.
package div_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // Accept-to-valid_o distance in cycles for each completion path.
  localparam int DIV_LATENCY         = 35;
  localparam int DIV_SPECIAL_LATENCY = 2;

  typedef logic [XLEN-1:0] data_bus_t;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREPARE = 3'd1,
    DIVIDE  = 3'd2,
    FIX     = 3'd3,
    DONE    = 3'd4
  } div_fsm_e;

  function automatic logic is_signed_op(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic is_quotient_op(input div_ops_e op);
    return (op == DIV_) || (op == DIVU_);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between issue logic and the divider.
// Latency: none (wires only).
// Backpressure: the issuer may only present valid_i while fu_state_o == FREE.
// Ports: valid_i, operation_i, dividend_i, divisor_i, kill_i (issuer -> divider);
//        fu_state_o, valid_o, result_o (divider -> issuer).
interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic      valid_i;
  div_ops_e  operation_i;
  data_bus_t dividend_i;
  data_bus_t divisor_i;
  logic      kill_i;
  fu_state_e fu_state_o;
  logic      valid_o;
  data_bus_t result_o;

  modport master (
    output valid_i, operation_i, dividend_i, divisor_i, kill_i,
    input  fu_state_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, operation_i, dividend_i, divisor_i, kill_i,
    output fu_state_o, valid_o, result_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of an unsigned XLEN-bit divide.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when to commit the result.
// Ports: rem, quo, divisor in; rem_next, quo_next out.
module div_step
  import div_sequencer_pkg::*;
(
  input  data_bus_t rem,
  input  data_bus_t quo,
  input  data_bus_t divisor,
  output data_bus_t rem_next,
  output data_bus_t quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // {rem, quo} << 1: the dividend MSB still held in quo moves into rem.
  assign rem_sh = {rem, quo[XLEN-1]};

  // rem < divisor holds on entry, so the difference lies strictly within
  // +/-2^XLEN and bit XLEN is a valid sign bit for an XLEN+1-bit subtract.
  assign trial = rem_sh - {1'b0, divisor};

  // On a negative trial rem_sh < divisor, so its top bit is zero and the
  // low XLEN bits are the whole restored remainder.
  assign rem_next = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V special cases.
// Latency: 35 cycles accept-to-valid_o; 2 cycles for divide-by-zero / signed overflow.
// Backpressure: fu_state_o = BUSY while an op is in flight; requests then are dropped.
// Ports: clk_i, rst_i (sync, active-high), bus (div_sequencer_if.slave).
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  div_sequencer_if.slave  bus
);

  div_fsm_e          state_q;
  div_fsm_e          state_d;

  div_ops_e          op_q;
  data_bus_t         a_q;
  data_bus_t         b_q;
  data_bus_t         divisor_q;
  data_bus_t         rem_q;
  data_bus_t         quo_q;
  data_bus_t         result_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  data_bus_t         a_abs;
  data_bus_t         b_abs;
  logic              div_zero;
  logic              overflow;
  logic              special;
  data_bus_t         special_res;
  data_bus_t         rem_next;
  data_bus_t         quo_next;
  data_bus_t         quo_fix;
  data_bus_t         rem_fix;
  data_bus_t         fix_res;

  // A new request can land in IDLE and also in DONE, which is what gives
  // one op per 35 cycles when requests are queued up behind each other.
  assign accept = ((state_q == IDLE) || (state_q == DONE)) &&
                  bus.valid_i && !bus.kill_i;

  // ---------------------------------------------------------------------
  // PREPARE: operand conditioning and special-case detection
  // ---------------------------------------------------------------------
  assign signed_op = is_signed_op(op_q);
  assign a_neg     = signed_op & a_q[XLEN-1];
  assign b_neg     = signed_op & b_q[XLEN-1];
  // -0x80000000 wraps to itself, which read as unsigned is the correct |a|.
  assign a_abs     = a_neg ? -a_q : a_q;
  assign b_abs     = b_neg ? -b_q : b_q;

  assign div_zero  = (b_q == '0);
  assign overflow  = signed_op && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign special   = div_zero | overflow;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = is_quotient_op(op_q) ? '1 : a_q;
    end else if (overflow) begin
      // Quotient of the overflow case is the dividend itself (0x80000000).
      special_res = is_quotient_op(op_q) ? a_q : '0;
    end
  end

  // ---------------------------------------------------------------------
  // DIVIDE: single shared iteration stage
  // ---------------------------------------------------------------------
  div_step u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // ---------------------------------------------------------------------
  // FIX: sign restoration and result selection
  // ---------------------------------------------------------------------
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;
  assign fix_res = is_quotient_op(op_q) ? quo_fix : rem_fix;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = bus.valid_i ? PREPARE : IDLE;
        PREPARE: state_d = special ? DONE : DIVIDE;
        DIVIDE:  state_d = (cnt_q == '0) ? FIX : DIVIDE;
        FIX:     state_d = DONE;
        DONE:    state_d = bus.valid_i ? PREPARE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.fu_state_o = BUSY;
    bus.valid_o    = 1'b0;
    case (state_q)
      IDLE: bus.fu_state_o = FREE;
      DONE: begin
        bus.fu_state_o = FREE;
        bus.valid_o    = 1'b1;
      end
      default: bus.fu_state_o = BUSY;
    endcase
  end

  assign bus.result_o = result_q;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= DIV_;
      a_q       <= '0;
      b_q       <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.operation_i;
        a_q  <= bus.dividend_i;
        b_q  <= bus.divisor_i;
      end

      if (state_q == PREPARE) begin
        divisor_q <= b_abs;
        quo_q     <= a_abs;
        rem_q     <= '0;
        q_neg_q   <= a_neg ^ b_neg;
        r_neg_q   <= a_neg;
        cnt_q     <= CNT_W'(XLEN-1);
      end

      if (state_q == DIVIDE) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end

      // A kill on the cycle that would load the result leaves the
      // previously delivered value on result_o.
      if (!bus.kill_i) begin
        if ((state_q == PREPARE) && special) begin
          result_q <= special_res;
        end else if (state_q == FIX) begin
          result_q <= fix_res;
        end
      end
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative radix-2 signed/unsigned integer divider for the M-extension DIV/DIVU/REM/REMU instructions. It has a control FSM that sequences a restoring shift-subtract datapath. It sits in the execute stage beside the ALU and MUL unit, and the issue logic treats it as a shared functional unit. It reports availability through `fu_state_e`. RISC-V special cases (divide by zero, signed overflow) complete through a short path.

## Interface
- `XLEN`, 32 (package value): operand and result width.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `valid_i` in 1: request strobe. Sampled only when `fu_state_o == FREE`.
- `operation_i` in `div_ops_e`: DIV_, DIVU_, REM_ or REMU_.
- `dividend_i` in `data_bus_t`: rs1 operand.
- `divisor_i` in `data_bus_t`: rs2 operand.
- `kill_i` in 1: pipeline flush. Aborts any operation in flight.
- `fu_state_o` out `fu_state_e`: FREE means a request is accepted this cycle; BUSY means requests are ignored.
- `valid_o` out 1: one-cycle pulse marking `result_o` valid.
- `result_o` out `data_bus_t`: quotient or remainder. Held until the next `valid_o`.

## Operation
- FSM states (`div_fsm_e`): IDLE, PREPARE, DIVIDE, FIX, DONE.
- **IDLE**
  - Outputs: FREE.
  - `valid_i & ~kill_i` latches the operands and operation, then goes to PREPARE.
- **PREPARE**
  - Signed ops: take the absolute value of each operand. Record `q_neg = sign(a) ^ sign(b)` and `r_neg = sign(a)`.
  - Unsigned ops: operands pass through unchanged; `q_neg = r_neg = 0`.
  - Detect divisor == 0, and signed overflow (a == 0x80000000 and b == -1, DIV_/REM_ only).
  - Special case goes to DONE with a preset result. Otherwise load quotient register = |a|, remainder = 0, step counter = XLEN-1, and go to DIVIDE.
- **DIVIDE**, one `div_step` per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − |b|. If trial ≥ 0: rem = trial, and the quotient LSB = 1. Otherwise the quotient LSB = 0.
  - Trial subtraction is XLEN+1 bits wide.
  - When the counter reaches 0, go to FIX.
- **FIX**: negate the quotient if `q_neg`, negate the remainder if `r_neg`. Select the quotient for DIV_/DIVU_ or the remainder for REM_/REMU_. Go to DONE.
- **DONE**
  - Registers `result_o`, pulses `valid_o`, drives `fu_state_o = FREE`.
  - Accepts a new request this same cycle, going to PREPARE. Otherwise goes to IDLE.
- Special-case results:
  - Divide by zero: DIV_/DIVU_ return 0xFFFFFFFF; REM_/REMU_ return the dividend.
  - Signed overflow: DIV_ returns 0x80000000; REM_ returns 0.
- `kill_i`:
  - From any state, the FSM goes to IDLE next cycle and no `valid_o` is produced.
  - If `kill_i` and `valid_i` are high in the same cycle, kill wins and nothing is accepted.
  - `result_o` keeps its last value.
- `valid_i` while BUSY is ignored and is not queued.

## Timing
- Request accepted at cycle T.
- Normal path:
  - PREPARE at T+1.
  - DIVIDE at T+2..T+33 (XLEN cycles).
  - FIX at T+34.
  - DONE at T+35: `valid_o` = 1. Latency 35 cycles, exported as `DIV_LATENCY`.
- Special path: PREPARE at T+1, DONE at T+2. Latency 2 cycles.
- `fu_state_o` is BUSY from T+1 through the cycle before DONE, and FREE in IDLE and DONE.
- Back-to-back throughput is one op per 35 cycles, because the next accept happens in the DONE cycle.
- Reset values: state IDLE, `fu_state_o` FREE, `valid_o` 0, `result_o` 0, counter 0. Reset mid-operation behaves like kill, with outputs forced to their reset values.

## Structure
- Add to `MGT_01_PACKAGE`:
  - `div_fsm_e` enum.
  - `DIV_LATENCY = 35`.
  - `DIV_SPECIAL_LATENCY = 2`.
- Reuse `div_ops_e`, `fu_state_e` and `data_bus_t` from the package.
- Sub-module `div_step`, purely combinational:
  - Inputs: rem, quo, divisor.
  - Outputs: the next rem and quo.
  - One instance.
- `div_sequencer` holds the FSM, counter, operand/sign registers and result mux.

## Test plan
- DIV_ 100/7 accepted at T: `valid_o` at T+35 with 14. REM_ on the same operands gives 2. REMU_ 100/7 gives 2.
- Signed rounding toward zero: DIV_ −7/2 gives 0xFFFFFFFD (−3); REM_ −7/2 gives 0xFFFFFFFF (−1); REM_ 7/−2 gives 1. DIVU_ 0xFFFFFFFF/2 gives 0x7FFFFFFF.
- Divide by zero: DIVU_ 5/0 gives 0xFFFFFFFF at T+2; REMU_ 5/0 gives 5; DIV_ −1/0 gives 0xFFFFFFFF.
- Signed overflow: DIV_ 0x80000000/0xFFFFFFFF gives 0x80000000 at T+2, and REM_ gives 0. DIVU_ with the same operands takes the normal path and gives 0 at T+35.
- `kill_i` at T+10: no `valid_o`, FREE at T+11, and a new DIV_ 9/3 accepted at T+11 gives 3 at T+46. Kill together with `valid_i` in IDLE: nothing accepted.
- Busy and reset behaviour:
  - `valid_i` held continuously: the second request is accepted in the DONE cycle, and the second `valid_o` comes exactly 35 cycles after the first.
  - Requests during BUSY are dropped.
  - `rst_i` at T+20: all outputs return to reset values next cycle.
